// File: rtl/vga_pkg.sv
// Shared timing defaults, pattern codes and colour-bar geometry for the
// VGA test-pattern generator.
package vga_pkg;

    localparam int TOTAL_COLS_DEF  = 800;
    localparam int TOTAL_ROWS_DEF  = 525;
    localparam int ACTIVE_COLS_DEF = 640;
    localparam int ACTIVE_ROWS_DEF = 480;
    localparam int VIDEO_WIDTH_DEF = 3;

    localparam int NUM_BARS = 8;
    localparam int PAT_W    = 3;

    typedef enum logic [PAT_W-1:0] {
        PAT_BLACK   = 3'd0,
        PAT_RED     = 3'd1,
        PAT_GRN     = 3'd2,
        PAT_BLU     = 3'd3,
        PAT_CHECKER = 3'd4,
        PAT_BARS    = 3'd5,
        PAT_BORDER  = 3'd6,
        PAT_RSVD    = 3'd7
    } pattern_e;

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Sync/pattern inputs and RGB/sync outputs of the pattern generator.
// The master drives the porched syncs and pattern select, the slave
// (the generator) returns re-timed syncs, colour and lock status.
interface vga_pattern_gen_if
    import vga_pkg::*;
#(
    parameter int VIDEO_WIDTH = VIDEO_WIDTH_DEF
);
    logic                   i_H_Sync;
    logic                   i_V_Sync;
    logic [PAT_W-1:0]       i_Pattern;
    logic                   o_H_Sync;
    logic                   o_V_Sync;
    logic [VIDEO_WIDTH-1:0] o_Red;
    logic [VIDEO_WIDTH-1:0] o_Grn;
    logic [VIDEO_WIDTH-1:0] o_Blu;
    logic                   o_Locked;

    modport master (
        output i_H_Sync, i_V_Sync, i_Pattern,
        input  o_H_Sync, o_V_Sync, o_Red, o_Grn, o_Blu, o_Locked
    );

    modport slave (
        input  i_H_Sync, i_V_Sync, i_Pattern,
        output o_H_Sync, o_V_Sync, o_Red, o_Grn, o_Blu, o_Locked
    );
endinterface

// File: rtl/vga_sync_to_count.sv
// Recovers column/row position from the porched syncs. A rising edge on
// V sync is the frame start; it zeroes the counters and sets the sticky
// lock flag. Between frame starts the counters free-run and wrap, so a
// missing or extra edge simply re-aligns at the next frame start.
module vga_sync_to_count
    import vga_pkg::*;
#(
    parameter int TOTAL_COLS = TOTAL_COLS_DEF,
    parameter int TOTAL_ROWS = TOTAL_ROWS_DEF
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          h_sync_i,
    input  logic                          v_sync_i,
    output logic [$clog2(TOTAL_COLS)-1:0] col_o,
    output logic [$clog2(TOTAL_ROWS)-1:0] row_o,
    output logic                          fs_o,
    output logic                          locked_o,
    output logic                          h_sync_o,
    output logic                          v_sync_o
);
    localparam int COL_W = $clog2(TOTAL_COLS);
    localparam int ROW_W = $clog2(TOTAL_ROWS);

    logic             v_prev_q;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             locked_q;
    logic             h_s1_q, v_s1_q;
    logic             fs;

    assign fs = v_sync_i & ~v_prev_q;

    // Next position: advance, wrap at end of line/frame; frame start wins.
    always_comb begin
        col_d = col_q + COL_W'(1);
        row_d = row_q;
        if (col_q == COL_W'(TOTAL_COLS - 1)) begin
            col_d = '0;
            row_d = (row_q == ROW_W'(TOTAL_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
        end
        if (fs) begin
            col_d = '0;
            row_d = '0;
        end
    end

    // Stage 1 registers: edge history, counters, lock flag, sync delay.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            v_prev_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            locked_q <= 1'b0;
            h_s1_q   <= 1'b0;
            v_s1_q   <= 1'b0;
        end else begin
            v_prev_q <= v_sync_i;
            col_q    <= col_d;
            row_q    <= row_d;
            locked_q <= locked_q | fs;
            h_s1_q   <= h_sync_i;
            v_s1_q   <= v_sync_i;
        end
    end

    assign col_o    = col_q;
    assign row_o    = row_q;
    assign fs_o     = fs;
    assign locked_o = locked_q;
    assign h_sync_o = h_s1_q;
    assign v_sync_o = v_s1_q;
endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator placed after the porch stage. Position tracking
// lives in vga_sync_to_count; this level latches the pattern at frame
// start, keeps the colour-bar counter and registers RGB together with the
// syncs so both leave two cycles after the input syncs.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int TOTAL_COLS  = TOTAL_COLS_DEF,
    parameter int TOTAL_ROWS  = TOTAL_ROWS_DEF,
    parameter int ACTIVE_COLS = ACTIVE_COLS_DEF,
    parameter int ACTIVE_ROWS = ACTIVE_ROWS_DEF,
    parameter int VIDEO_WIDTH = VIDEO_WIDTH_DEF
) (
    input logic              CLK,
    input logic              RST_N,
    vga_pattern_gen_if.slave vif
);
    localparam int COL_W    = $clog2(TOTAL_COLS);
    localparam int ROW_W    = $clog2(TOTAL_ROWS);
    localparam int BAR_W    = ACTIVE_COLS / NUM_BARS;
    localparam int BAR_PX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int BAR_K_W  = $clog2(NUM_BARS);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             fs;
    logic             locked;
    logic             h_s1, v_s1;

    vga_sync_to_count #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS)
    ) u_sync_to_count (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .h_sync_i (vif.i_H_Sync),
        .v_sync_i (vif.i_V_Sync),
        .col_o    (col),
        .row_o    (row),
        .fs_o     (fs),
        .locked_o (locked),
        .h_sync_o (h_s1),
        .v_sync_o (v_s1)
    );

    pattern_e               pat_q, pat_d;
    logic [BAR_PX_W-1:0]    bar_px_q, bar_px_d;
    logic [BAR_K_W-1:0]     bar_k_q, bar_k_d;
    logic                   col_wrap;
    logic                   active;
    logic [VIDEO_WIDTH-1:0] red_d, grn_d, blu_d;
    logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;
    logic                   h_q, v_q;

    assign col_wrap = (col == COL_W'(TOTAL_COLS - 1));

    // Pattern latch and bar counter; the bar counter tracks col so that
    // bar_k_q equals col/BAR_W without a divider.
    always_comb begin
        pat_d    = fs ? pattern_e'(vif.i_Pattern) : pat_q;
        bar_px_d = bar_px_q + BAR_PX_W'(1);
        bar_k_d  = bar_k_q;
        if (bar_px_q == BAR_PX_W'(BAR_W - 1)) begin
            bar_px_d = '0;
            bar_k_d  = bar_k_q + BAR_K_W'(1);
        end
        if (fs || col_wrap) begin
            bar_px_d = '0;
            bar_k_d  = '0;
        end
    end

    // Colour for the current position; black outside the visible area or
    // before the first frame start.
    always_comb begin
        red_d  = '0;
        grn_d  = '0;
        blu_d  = '0;
        active = locked && (col < COL_W'(ACTIVE_COLS)) && (row < ROW_W'(ACTIVE_ROWS));
        if (active) begin
            case (pat_q)
                PAT_RED: red_d = '1;
                PAT_GRN: grn_d = '1;
                PAT_BLU: blu_d = '1;
                PAT_CHECKER: begin
                    if (col[5] ^ row[5]) begin
                        red_d = '1;
                        grn_d = '1;
                        blu_d = '1;
                    end
                end
                PAT_BARS: begin
                    red_d = {VIDEO_WIDTH{bar_k_q[2]}};
                    grn_d = {VIDEO_WIDTH{bar_k_q[1]}};
                    blu_d = {VIDEO_WIDTH{bar_k_q[0]}};
                end
                PAT_BORDER: begin
                    if (col == '0 || col == COL_W'(ACTIVE_COLS - 1) ||
                        row == '0 || row == ROW_W'(ACTIVE_ROWS - 1)) begin
                        red_d = '1;
                        grn_d = '1;
                        blu_d = '1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage 2 registers: pattern/bar state plus aligned RGB and syncs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pat_q    <= PAT_BLACK;
            bar_px_q <= '0;
            bar_k_q  <= '0;
            red_q    <= '0;
            grn_q    <= '0;
            blu_q    <= '0;
            h_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            pat_q    <= pat_d;
            bar_px_q <= bar_px_d;
            bar_k_q  <= bar_k_d;
            red_q    <= red_d;
            grn_q    <= grn_d;
            blu_q    <= blu_d;
            h_q      <= h_s1;
            v_q      <= v_s1;
        end
    end

    assign vif.o_Red    = red_q;
    assign vif.o_Grn    = grn_q;
    assign vif.o_Blu    = blu_q;
    assign vif.o_H_Sync = h_q;
    assign vif.o_V_Sync = v_q;
    assign vif.o_Locked = locked;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: a full-size 640x480 instance and a small
// 40x36 instance share the same stimulus. A frame-position model (linear
// pixel index since frame start, divided out into col/row) predicts every
// output on every cycle; directed spot checks pin down key pixels.
module tb_vga_pattern_gen;
    import vga_pkg::*;

    localparam int NI = 2;

    logic CLK = 1'b0;
    logic RST_N;
    always #20 CLK = ~CLK;

    vga_pattern_gen_if #(.VIDEO_WIDTH(3)) vif0 ();
    vga_pattern_gen_if #(.VIDEO_WIDTH(3)) vif1 ();

    vga_pattern_gen dut0 (.CLK(CLK), .RST_N(RST_N), .vif(vif0));

    vga_pattern_gen #(
        .TOTAL_COLS(48), .TOTAL_ROWS(40), .ACTIVE_COLS(40), .ACTIVE_ROWS(36), .VIDEO_WIDTH(3)
    ) dut1 (.CLK(CLK), .RST_N(RST_N), .vif(vif1));

    logic       obs_h [NI];
    logic       obs_v [NI];
    logic       obs_l [NI];
    logic [8:0] obs_rgb [NI];

    assign obs_h[0]   = vif0.o_H_Sync;
    assign obs_v[0]   = vif0.o_V_Sync;
    assign obs_l[0]   = vif0.o_Locked;
    assign obs_rgb[0] = {vif0.o_Red, vif0.o_Grn, vif0.o_Blu};
    assign obs_h[1]   = vif1.o_H_Sync;
    assign obs_v[1]   = vif1.o_V_Sync;
    assign obs_l[1]   = vif1.o_Locked;
    assign obs_rgb[1] = {vif1.o_Red, vif1.o_Grn, vif1.o_Blu};

    int checks = 0;
    int errors = 0;

    logic       cur_h, cur_v;
    logic [2:0] cur_p;

    // reference model state
    int         pos_m [NI];
    int         pat_m [NI];
    bit         lock_m [NI];
    bit         prev_v_m;
    bit         hq [$];
    bit         vq [$];
    bit         exp_h, exp_v;
    logic [8:0] exp_rgb [NI];

    function automatic int g_tc(input int i); return (i == 0) ? 800 : 48; endfunction
    function automatic int g_tr(input int i); return (i == 0) ? 525 : 40; endfunction
    function automatic int g_ac(input int i); return (i == 0) ? 640 : 40; endfunction
    function automatic int g_ar(input int i); return (i == 0) ? 480 : 36; endfunction

    // Expected {R,G,B} for linear frame index p of instance i.
    function automatic logic [8:0] pix(input int i, input int p, input int pat, input bit lk);
        int c, r, k;
        logic [2:0] f, z;
        f = 3'b111;
        z = 3'b000;
        c = p % g_tc(i);
        r = (p / g_tc(i)) % g_tr(i);
        if (!lk || c >= g_ac(i) || r >= g_ar(i)) return 9'd0;
        case (pat)
            1: return {f, z, z};
            2: return {z, f, z};
            3: return {z, z, f};
            4: return ((((c / 32) + (r / 32)) % 2) == 1) ? {f, f, f} : 9'd0;
            5: begin
                k = c / (g_ac(i) / 8);
                return {(k >= 4) ? f : z, (((k / 2) % 2) == 1) ? f : z, ((k % 2) == 1) ? f : z};
            end
            6: return (c == 0 || c == g_ac(i) - 1 || r == 0 || r == g_ar(i) - 1) ? {f, f, f} : 9'd0;
            default: return 9'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic apply();
        vif0.i_H_Sync  = cur_h;
        vif0.i_V_Sync  = cur_v;
        vif0.i_Pattern = cur_p;
        vif1.i_H_Sync  = cur_h;
        vif1.i_V_Sync  = cur_v;
        vif1.i_Pattern = cur_p;
    endtask

    // Advance the model over one clock edge using the inputs just sampled.
    task automatic model_edge();
        bit fs;
        if (!RST_N) begin
            hq.delete();
            vq.delete();
            hq.push_back(1'b0);
            vq.push_back(1'b0);
            exp_h    = 1'b0;
            exp_v    = 1'b0;
            prev_v_m = 1'b0;
            for (int i = 0; i < NI; i++) begin
                exp_rgb[i] = 9'd0;
                pos_m[i]   = 0;
                pat_m[i]   = 0;
                lock_m[i]  = 1'b0;
            end
        end else begin
            hq.push_back(cur_h);
            vq.push_back(cur_v);
            exp_h    = hq.pop_front();
            exp_v    = vq.pop_front();
            fs       = cur_v && !prev_v_m;
            prev_v_m = cur_v;
            for (int i = 0; i < NI; i++) begin
                exp_rgb[i] = pix(i, pos_m[i], pat_m[i], lock_m[i]);
                if (fs) begin
                    pos_m[i]  = 0;
                    pat_m[i]  = int'(cur_p);
                    lock_m[i] = 1'b1;
                end else begin
                    pos_m[i]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("hsync%0d", i), {8'd0, obs_h[i]}, {8'd0, exp_h});
            chk($sformatf("vsync%0d", i), {8'd0, obs_v[i]}, {8'd0, exp_v});
            chk($sformatf("locked%0d", i), {8'd0, obs_l[i]}, {8'd0, lock_m[i]});
            chk($sformatf("rgb%0d", i), obs_rgb[i], exp_rgb[i]);
        end
        cur_h = 1'($urandom_range(0, 1));
        apply();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic setv(input logic v);
        cur_v = v;
        apply();
    endtask

    // Produce a V rising edge with pattern p; returns just after edge T.
    task automatic frame_start(input logic [2:0] p);
        setv(1'b0);
        tick();
        cur_p = p;
        setv(1'b1);
        tick();
        chk("lock_after_fs", {8'd0, obs_l[0]}, 9'd1);
    endtask

    initial begin
        RST_N = 1'b0;
        cur_h = 1'b0;
        cur_v = 1'b0;
        cur_p = 3'd0;
        apply();
        run(3);
        chk("rst_locked", {8'd0, obs_l[0]}, 9'd0);
        chk("rst_rgb", obs_rgb[0], 9'd0);
        RST_N = 1'b1;

        // no V edge: stays unlocked and black, syncs only delayed
        for (int n = 0; n < 2000; n++) begin
            cur_p = 3'($urandom_range(0, 7));
            apply();
            tick();
        end
        chk("idle_locked", {8'd0, obs_l[0]}, 9'd0);
        chk("idle_rgb", obs_rgb[0], 9'd0);

        // pattern 1: first visible pixel two cycles after the edge
        frame_start(3'd1);
        setv(1'b0);
        tick();
        chk("red_px0", obs_rgb[0], 9'o700);
        run(639);
        chk("red_px639", obs_rgb[0], 9'o700);
        tick();
        chk("red_px640_blank", obs_rgb[0], 9'd0);
        run(1900);

        // mid-frame pattern change holds until next frame start
        cur_p = 3'd2;
        apply();
        run(2000);
        chk("switch_hold_red", obs_rgb[0], 9'o700);
        frame_start(3'd2);
        setv(1'b0);
        tick();
        chk("switch_green", obs_rgb[0], 9'o070);
        run(200);

        // colour bars, row 10
        frame_start(3'd5);
        setv(1'b0);
        tick();
        chk("bar0_black", obs_rgb[0], 9'd0);
        run(8080);
        chk("bar1_blue", obs_rgb[0], 9'o007);
        run(80);
        chk("bar2_green", obs_rgb[0], 9'o070);
        run(400);
        chk("bar7_white", obs_rgb[0], 9'o777);
        run(200);

        // checkerboard
        frame_start(3'd4);
        setv(1'b0);
        tick();
        run(31);
        chk("chk_c31", obs_rgb[0], 9'd0);
        tick();
        chk("chk_c32", obs_rgb[0], 9'o777);
        run(2500);

        // border
        frame_start(3'd6);
        setv(1'b0);
        tick();
        chk("border_r0c0", obs_rgb[0], 9'o777);
        run(801);
        chk("border_inside", obs_rgb[0], 9'd0);
        run(638);
        chk("border_r1c639", obs_rgb[0], 9'o777);
        run(2500);

        // random V edges (missing/extra) and random pattern selects
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 399) == 0) cur_v = ~cur_v;
            cur_p = 3'($urandom_range(0, 7));
            apply();
            tick();
        end

        // reset mid-frame, then re-lock on next V edge
        frame_start(3'd1);
        setv(1'b0);
        run(1000);
        RST_N = 1'b0;
        tick();
        chk("midrst_locked", {8'd0, obs_l[0]}, 9'd0);
        chk("midrst_rgb", obs_rgb[0], 9'd0);
        chk("midrst_hsync", {8'd0, obs_h[0]}, 9'd0);
        RST_N = 1'b1;
        run(500);
        chk("postrst_unlocked", {8'd0, obs_l[0]}, 9'd0);
        frame_start(3'd3);
        setv(1'b0);
        tick();
        chk("relock_blue", obs_rgb[0], 9'o007);
        run(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
